// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front-end for a word-wide RAM with registered reads; sub-word stores use read-modify-write.
// Latency: error 1, word store 2, load 3, sub-word store 4 cycles to resp_valid; holds the response until resp_ready.
module mem_access_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_r_wn,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {IDLE, RD, RD_CAP, RMW_RD, RMW_CAP, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              ram_r_wn_q, ram_r_wn_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              req_err;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] merged;

  always_comb begin
    req_err = (req_size == 2'b11)
            || (req_size == 2'b01 && req_addr[0] != 1'b0)
            || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            || (req_addr[31:ADDR_W+2] != '0);

    // Aligned halfwords sit at lane 0 or 2, so a byte-granular shift serves both sizes.
    shifted = ram_data_out >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   ext = signed_q ? {{(DATA_W-8){shifted[7]}}, shifted[7:0]}
                              : {{(DATA_W-8){1'b0}}, shifted[7:0]};
      2'b01:   ext = signed_q ? {{(DATA_W-16){shifted[15]}}, shifted[15:0]}
                              : {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ext = ram_data_out;
    endcase

    merged = ram_data_out;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    ram_r_wn_d    = 1'b1;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    lane_d        = lane_q;
    size_d        = size_q;
    signed_d      = signed_q;
    wdata_d       = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d  = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          lane_d       = req_addr[1:0];
          size_d       = req_size;
          signed_d     = req_signed;
          wdata_d      = req_wdata[15:0];
          if (req_err) begin
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            ram_address_d = req_addr[ADDR_W+1:2];
            if (!req_we) begin
              state_d = RD;
            end else if (req_size == 2'b10) begin
              ram_r_wn_d    = 1'b0;
              ram_data_in_d = req_wdata;
              state_d       = WRITE;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      RD:     state_d = RD_CAP;
      RMW_RD: state_d = RMW_CAP;
      RD_CAP: begin
        resp_rdata_d = ext;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RMW_CAP: begin
        ram_r_wn_d    = 1'b0;
        ram_data_in_d = merged;
        state_d       = WRITE;
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      ram_r_wn_q    <= 1'b1;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      lane_q        <= '0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      ram_r_wn_q    <= ram_r_wn_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      lane_q        <= lane_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      wdata_q       <= wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign ram_r_wn    = ram_r_wn_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word RAM model plus a byte-addressed shadow memory as reference,
// directed cases from the plan, then randomized requests with random response backpressure.
module tb_mem_access_unit;
  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_r_wn;
  logic [11:0] ram_address;
  logic [31:0] ram_data_in, ram_data_out;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .ram_r_wn(ram_r_wn), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM: write on r_wn=0 edge, registered read otherwise.
  logic [31:0] ram [0:4095];
  logic        ram_clear;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ram_data_out <= '0;
    end else if (!ram_r_wn) begin
      ram[ram_address] <= ram_data_in;
    end else begin
      ram_data_out <= ram[ram_address];
    end
  end

  logic [7:0] sm [0:16383];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
    int n = 1 << size;
    logic [63:0] v = '0;
    logic [63:0] mask;
    for (int i = 0; i < n; i++) v = v | (64'(sm[addr[13:0] + 14'(i)]) << (8 * i));
    mask = (64'd1 << (8 * n)) - 64'd1;
    if (sgn && v[8 * n - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int n = 1 << size;
    for (int i = 0; i < n; i++) sm[addr[13:0] + 14'(i)] = wdata[8 * i +: 8];
  endtask

  function automatic logic [31:0] shadow_word(input logic [11:0] w);
    return {sm[{w, 2'd3}], sm[{w, 2'd2}], sm[{w, 2'd1}], sm[{w, 2'd0}]};
  endfunction

  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input int bp,
                      output logic [31:0] rdata, output logic err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat, lat, nwr, wr_cyc;
    logic [11:0] wr_addr;
    exp_err   = model_err(size, addr);
    exp_rdata = (!exp_err && !we) ? model_load(size, sgn, addr) : 32'h0;
    exp_lat   = exp_err ? 1 : (we ? ((size == 2'b10) ? 2 : 4) : 3);
    check("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; resp_ready = (bp == 0);
    step();
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; nwr = 0; wr_cyc = 0; wr_addr = '0;
    for (int k = 1; k <= 10; k++) begin
      if (!ram_r_wn) begin nwr++; wr_cyc = k; wr_addr = ram_address; end
      if (resp_valid) begin lat = k; break; end
      step();
    end
    check("resp_latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("req_ready_busy", 32'(req_ready), 32'h0);
    check("write_count", 32'(nwr), (!exp_err && we) ? 32'h1 : 32'h0);
    if (!exp_err && we) begin
      check("write_cycle", 32'(wr_cyc), 32'(exp_lat - 1));
      check("write_addr", 32'(wr_addr), 32'(addr[13:2]));
      model_store(size, addr, wdata);
      check("ram_word", ram[addr[13:2]], shadow_word(addr[13:2]));
    end
    rdata = resp_rdata;
    err   = resp_err;
    for (int k = 0; k < bp; k++) begin
      // A competing word store must be ignored while the response is stalled.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = $urandom;
      step();
      check("bp_valid", 32'(resp_valid), 32'h1);
      check("bp_rdata", resp_rdata, rdata);
      check("bp_err", 32'(resp_err), 32'(err));
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_r_wn", 32'(ram_r_wn), 32'h1);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    step();
    check("post_resp_valid", 32'(resp_valid), 32'h0);
    check("post_req_ready", 32'(req_ready), 32'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          nwr;
    for (int i = 0; i < 16384; i++) sm[i] = 8'h0;
    rst = 1'b1; ram_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_r_wn", 32'(ram_r_wn), 32'h1);
    check("rst_address", 32'(ram_address), 32'h0);
    check("rst_data_in", ram_data_in, 32'h0);
    rst = 1'b0; ram_clear = 1'b0;
    step();

    xact(1, 2'b10, 0, 32'h0, 32'hABCD0123, 0, rd, er);
    check("lit_word0", ram[0], 32'hABCD0123);
    xact(0, 2'b10, 0, 32'h0, 32'h0, 0, rd, er);
    check("lit_load_word", rd, 32'hABCD0123);

    xact(1, 2'b10, 0, 32'h4, 32'h11223344, 0, rd, er);
    xact(1, 2'b00, 0, 32'h6, 32'h000000AA, 0, rd, er);
    check("lit_byte_merge", ram[1], 32'h11AA3344);
    xact(0, 2'b00, 1, 32'h6, 32'h0, 0, rd, er);
    check("lit_lb", rd, 32'hFFFFFFAA);
    xact(0, 2'b00, 0, 32'h6, 32'h0, 0, rd, er);
    check("lit_lbu", rd, 32'h000000AA);

    xact(1, 2'b01, 0, 32'h2, 32'h00008001, 0, rd, er);
    check("lit_half_merge", ram[0], 32'h80010123);
    xact(0, 2'b01, 1, 32'h2, 32'h0, 0, rd, er);
    check("lit_lh", rd, 32'hFFFF8001);
    xact(0, 2'b01, 0, 32'h0, 32'h0, 0, rd, er);
    check("lit_lhu", rd, 32'h00000123);

    xact(1, 2'b10, 0, 32'h2, 32'h12345678, 0, rd, er);
    check("lit_err_misalign", 32'(er), 32'h1);
    xact(0, 2'b10, 0, 32'h00004000, 32'h0, 0, rd, er);
    check("lit_err_range", 32'(er), 32'h1);
    xact(0, 2'b11, 0, 32'h0, 32'h0, 0, rd, er);
    check("lit_err_size", 32'(er), 32'h1);

    xact(0, 2'b10, 0, 32'h4, 32'h0, 3, rd, er);
    check("lit_bp_load", rd, 32'h11AA3344);

    // Reset while the RMW read is on the bus: store must be abandoned.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h5; req_wdata = 32'h000000EE;
    step();
    req_valid = 1'b0;
    check("rmw_rd_r_wn", 32'(ram_r_wn), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_req_ready", 32'(req_ready), 32'h1);
    check("rstmid_resp_valid", 32'(resp_valid), 32'h0);
    check("rstmid_r_wn", 32'(ram_r_wn), 32'h1);
    nwr = 0;
    for (int k = 0; k < 6; k++) begin
      if (!ram_r_wn) nwr++;
      step();
    end
    check("rstmid_no_write", 32'(nwr), 32'h0);
    check("rstmid_word1", ram[1], 32'h11AA3344);

    // Reset while the write strobe is out: the write lands, the response is dropped.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
    step();
    req_valid = 1'b0;
    check("wr_strobe", 32'(ram_r_wn), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_store(2'b10, 32'h8, 32'hCAFEF00D);
    check("rstwr_word2", ram[2], 32'hCAFEF00D);
    check("rstwr_resp_valid", 32'(resp_valid), 32'h0);
    check("rstwr_r_wn", 32'(ram_r_wn), 32'h1);
    step();

    for (int n = 0; n < 300; n++) begin
      logic        we, sgn;
      logic [1:0]  size;
      logic [31:0] addr;
      int          bp;
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0)
        addr = (32'($urandom_range(1, 32'h3FFFF)) << 14) | 32'($urandom_range(0, 63));
      else
        addr = 32'($urandom_range(0, 63));
      bp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      xact(we, size, sgn, addr, $urandom, bp, rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the word-wide RAM bank (12-bit word address, 32-bit data, single r_wn strobe, no byte enables).
- Accepts byte-addressed byte, halfword and word requests from the core over a valid/ready handshake, and checks alignment and range.
- Performs read-modify-write for sub-word stores, and returns sign- or zero-extended load data over a valid/ready response channel.
- Sole driver of the RAM's r_wn, address and data_in.

Parameters:
- ADDR_W, 12, RAM word-address width; byte address space = 2^(ADDR_W+2) bytes.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_signed  input  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low 8/16/32 bits are used.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out of range, or reserved size.
- ram_r_wn  output  1  to RAM r_wn (1 read, 0 write).
- ram_address  output  ADDR_W  to RAM address (word index = req_addr[ADDR_W+1:2]).
- ram_data_in  output  32  to RAM data_in.
- ram_data_out  input  32  from RAM data_out.

Behaviour:
- RAM contract:
  - Write occurs at a rising edge where r_wn=0.
  - Read data is registered: valid in the cycle after the address is presented with r_wn=1.
- All outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_r_wn=1, ram_address=0, ram_data_in=0, state=IDLE.
- ram_r_wn is 0 in exactly one cycle per store, and only in the WRITE state. It is 1 at all other times.
- FSM states: IDLE, RD, RD_CAP, RMW_RD, RMW_CAP, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request, drop req_ready and decode it.
  - Error (any of):
    - size 11;
    - half with addr[0]!=0;
    - word with addr[1:0]!=0;
    - addr[31:ADDR_W+2]!=0.
  - Error -> RESP with err=1; the RAM is untouched.
  - Load -> RD.
  - Word store -> WRITE.
  - Byte/half store -> RMW_RD.
- RD / RMW_RD: drive ram_address with r_wn=1 for one cycle, then go to RD_CAP / RMW_CAP.
- RD_CAP:
  - Capture ram_data_out.
  - Byte lane = addr[1:0], little-endian (byte 0 = bits[7:0]); half lane = addr[1].
  - Extend per req_signed into resp_rdata, then -> RESP.
- RMW_CAP: merge req_wdata into the selected lane of ram_data_out; other lanes are unchanged. Then -> WRITE.
- WRITE: drive r_wn=0 with the address and the merged (or full-word) data for one cycle, then -> RESP.
- RESP:
  - resp_valid=1; rdata and err are held stable until resp_ready.
  - On resp_valid&resp_ready -> IDLE; req_ready=1 next cycle.
- Latency, with acceptance edge = end of cycle 0:
  - error: resp_valid in cycle 1;
  - word store: write in cycle 1, resp in cycle 2;
  - load: address in cycle 1, resp in cycle 3;
  - sub-word store: read in cycle 1, write in cycle 3, resp in cycle 4.
- One request in flight at a time; no pipelining.
- req_* inputs are ignored outside IDLE. Request inputs may change after acceptance without effect.
- Reset mid-operation:
  - The next edge returns to IDLE with reset values. No later RAM write occurs.
  - A write already presented (r_wn=0) in the reset cycle completes at that edge.
  - The pending response is discarded.
- Reset during an RMW read aborts the store; the RAM word is unchanged.
- Reset has priority over all handshakes.

Test Plan:
- Word store addr 0x0 data 0xABCD0123, then word load addr 0x0.
  - Store: ram_r_wn=0 only in cycle 1, ram_address=0x000.
  - Load: resp_rdata=0xABCD0123 in cycle 3, err=0.
- Word 1 preloaded with 0x11223344; byte store addr 0x6 data 0xAA.
  - Word 1 becomes 0x11AA3344.
  - Signed byte load 0x6 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Word 0 = 0xABCD0123; half store addr 0x2 data 0x8001.
  - Word becomes 0x80010123.
  - Signed half load 0x2 -> 0xFFFF8001; unsigned half load 0x0 -> 0x00000123.
- Error cases, each with resp_err=1 in cycle 1, resp_rdata=0, and ram_r_wn never 0:
  - word store addr 0x2;
  - load addr 0x00004000;
  - size 11.
- Backpressure: hold resp_ready=0 for 3 cycles after resp_valid.
  - resp_valid, rdata and err stay stable; req_ready=0.
  - A new req_valid is ignored until the response handshake completes.
- Byte store to 0x5 with rst=1 during the RMW_RD cycle:
  - No r_wn=0 cycle; word 1 is unchanged.
  - After reset, req_ready=1, resp_valid=0 and ram_r_wn=1.
